wb_result_select: RTL and testbench

//  Parametrised write-back stage for the MIPS32 pipeline. Supersedes the 2-input MemtoReg mux.

---
 rtl/wb_result_select.sv | 137 +++++++++++++
 tb/tb_wb_result_select.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_select.sv
// Write-back stage: picks one of NUM_SRC results, aligns/extends sub-word loads
// from the memory source, and registers the register-file write port.
module wb_result_select #(
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 4,
  parameter int SEL_W      = 2,
  parameter int MEM_SRC    = 1,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Stall_WB,
  input  logic                      Flush_WB,
  input  logic                      Valid_In,
  input  logic [NUM_SRC*DATA_W-1:0] Src_Data,
  input  logic [SEL_W-1:0]          Result_Sel,
  input  logic [1:0]                Load_Size,
  input  logic                      Load_Signed,
  input  logic [OFF_W-1:0]          Byte_Offset,
  input  logic                      RegWrite_In,
  input  logic [REG_ADDR_W-1:0]     Write_Reg_In,
  output logic [DATA_W-1:0]         Write_Data_WB,
  output logic [REG_ADDR_W-1:0]     Write_Reg_WB,
  output logic                      RegWrite_WB,
  output logic                      Valid_WB,
  output logic                      Align_Err,
  output logic                      Sel_Err,
  output logic [CNT_W-1:0]          Retire_Count
);

  // One extra bit so NUM_SRC == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W + 1)'(NUM_SRC);

  logic [DATA_W-1:0]     src_arr [NUM_SRC];
  logic                  sel_ok;
  logic                  is_mem;
  logic [DATA_W-1:0]     sel_data;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [DATA_W-1:0]     aligned_data;
  logic                  misaligned;

  logic [DATA_W-1:0]     data_q, data_d;
  logic [REG_ADDR_W-1:0] reg_q, reg_d;
  logic                  we_q, we_d;
  logic                  valid_q, valid_d;
  logic                  aerr_q, aerr_d;
  logic                  serr_q, serr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_arr[gi] = Src_Data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign sel_ok = ({1'b0, Result_Sel} < NUM_SRC_L);
  assign is_mem = sel_ok && (Result_Sel == SEL_W'(MEM_SRC));

  // Out-of-range selectors fall back to source 0.
  always_comb begin
    sel_data = src_arr[0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (sel_ok && (Result_Sel == SEL_W'(k))) sel_data = src_arr[k];
    end
  end

  assign byte_val = sel_data[{Byte_Offset, 3'b000} +: 8];
  assign half_val = sel_data[{Byte_Offset[OFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    aligned_data = sel_data;
    if (is_mem) begin
      if (Load_Size == 2'b00)
        aligned_data = {{(DATA_W-8){Load_Signed & byte_val[7]}}, byte_val};
      else if (Load_Size == 2'b01)
        aligned_data = {{(DATA_W-16){Load_Signed & half_val[15]}}, half_val};
    end
  end

  assign misaligned = ((Load_Size == 2'b01) & Byte_Offset[0]) |
                      (Load_Size[1] & (|Byte_Offset));

  always_comb begin
    data_d  = data_q;
    reg_d   = reg_q;
    we_d    = we_q;
    valid_d = valid_q;
    aerr_d  = aerr_q;
    serr_d  = serr_q;
    cnt_d   = cnt_q;
    if (Flush_WB) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      aerr_d  = 1'b0;
    end else if (!Stall_WB) begin
      valid_d = Valid_In;
      we_d    = Valid_In & RegWrite_In & (Write_Reg_In != '0);
      reg_d   = Write_Reg_In;
      data_d  = aligned_data;
      aerr_d  = Valid_In & is_mem & misaligned;
      serr_d  = serr_q | (Valid_In & ~sel_ok);
      if (Valid_In) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q  <= '0;
      reg_q   <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      serr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      reg_q   <= reg_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
      serr_q  <= serr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Write_Data_WB = data_q;
  assign Write_Reg_WB  = reg_q;
  assign RegWrite_WB   = we_q;
  assign Valid_WB      = valid_q;
  assign Align_Err     = aerr_q;
  assign Sel_Err       = serr_q;
  assign Retire_Count  = cnt_q;

endmodule

// File: tb/tb_wb_result_select.sv
// Bench for wb_result_select: directed steps then random traffic, checked
// against a behavioural model (3 sources so an out-of-range selector exists).
module tb_wb_result_select;

  localparam int DATA_W = 32;
  localparam int NUM_SRC = 3;
  localparam int SEL_W = 2;
  localparam int MEM_SRC = 1;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst, stall, flush, vin, lsgn, rw;
  logic [31:0] src0, src1, src2;
  logic [1:0]  sel, lsize, off;
  logic [4:0]  wreg;

  logic [31:0] wd_o;
  logic [4:0]  wr_o;
  logic        we_o, v_o, ae_o, se_o;
  logic [3:0]  cnt_o;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  // behavioural model state
  logic [31:0] m_data;
  logic [4:0]  m_reg;
  logic        m_we, m_valid, m_aerr, m_serr;
  int          m_cnt;

  always #5 clk = ~clk;

  wb_result_select #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .MEM_SRC(MEM_SRC),
    .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .Clk(clk), .Reset(rst), .Stall_WB(stall), .Flush_WB(flush), .Valid_In(vin),
    .Src_Data({src2, src1, src0}), .Result_Sel(sel), .Load_Size(lsize),
    .Load_Signed(lsgn), .Byte_Offset(off), .RegWrite_In(rw), .Write_Reg_In(wreg),
    .Write_Data_WB(wd_o), .Write_Reg_WB(wr_o), .RegWrite_WB(we_o), .Valid_WB(v_o),
    .Align_Err(ae_o), .Sel_Err(se_o), .Retire_Count(cnt_o)
  );

  function automatic logic [31:0] model_data();
    logic [31:0] s, r;
    if (sel >= 3) return src0;
    s = (sel == 0) ? src0 : (sel == 1) ? src1 : src2;
    if (sel != MEM_SRC) return s;
    if (lsize == 0) begin
      r = (s >> (8 * off)) & 32'hFF;
      if (lsgn && r >= 128) r = r + 32'hFFFFFF00;
    end else if (lsize == 1) begin
      r = (s >> (16 * (off / 2))) & 32'hFFFF;
      if (lsgn && r >= 32768) r = r + 32'hFFFF0000;
    end else r = s;
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_data = 0; m_reg = 0; m_we = 0; m_valid = 0; m_aerr = 0; m_serr = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_aerr = 0;
    end else if (!stall) begin
      m_data  = model_data();
      m_reg   = wreg;
      m_valid = vin;
      m_we    = vin && rw && wreg != 0;
      m_aerr  = vin && sel == MEM_SRC &&
                ((lsize == 1 && off % 2 == 1) || (lsize >= 2 && off != 0));
      if (vin && sel >= NUM_SRC) m_serr = 1;
      if (vin) m_cnt = (m_cnt + 1) % 16;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    txn++;
    $display("txn %0d %s: data=%08h reg=%0d we=%b v=%b ae=%b se=%b cnt=%0d",
             txn, tag, wd_o, wr_o, we_o, v_o, ae_o, se_o, cnt_o);
    check({tag, ".data"},  wd_o, m_data);
    check({tag, ".reg"},   32'(wr_o), 32'(m_reg));
    check({tag, ".we"},    32'(we_o), 32'(m_we));
    check({tag, ".valid"}, 32'(v_o), 32'(m_valid));
    check({tag, ".aerr"},  32'(ae_o), 32'(m_aerr));
    check({tag, ".serr"},  32'(se_o), 32'(m_serr));
    check({tag, ".cnt"},   32'(cnt_o), m_cnt);
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; vin = 0; lsgn = 0; rw = 0;
    src0 = 0; src1 = 0; src2 = 0; sel = 0; lsize = 2; off = 0; wreg = 0;
  endtask

  task automatic rand_inputs();
    src0 = $urandom; src1 = $urandom; src2 = $urandom;
    sel = 2'($urandom); lsize = 2'($urandom); off = 2'($urandom);
    lsgn = 1'($urandom); rw = 1'($urandom); wreg = 5'($urandom); vin = 1'($urandom);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    cycle("reset0");
    cycle("reset1");
    check("reset_cnt_const", 32'(cnt_o), 0);
    rst = 0;

    // 1: plain ALU-style capture
    src0 = 32'h11111111; sel = 0; vin = 1; rw = 1; wreg = 5;
    cycle("t1");
    check("t1_data_const", wd_o, 32'h11111111);
    check("t1_cnt_const", 32'(cnt_o), 1);

    // 2: sub-word loads from the memory source
    src1 = 32'h80F0A17F; sel = 1; lsize = 0; off = 1; lsgn = 1;
    cycle("t2_sb");
    check("t2_sb_const", wd_o, 32'hFFFFFFA1);
    off = 0; lsgn = 0;
    cycle("t2_ub");
    check("t2_ub_const", wd_o, 32'h0000007F);
    lsize = 1; off = 2; lsgn = 1;
    cycle("t2_sh");
    check("t2_sh_const", wd_o, 32'hFFFF80F0);

    // 3: misaligned half
    off = 3;
    cycle("t3_mis");
    check("t3_aerr_const", 32'(ae_o), 1);
    check("t3_data_const", wd_o, 32'hFFFF80F0);
    off = 0; lsize = 2;
    cycle("t3_clr");
    check("t3_aerr_clr", 32'(ae_o), 0);

    // 4: write to $0 suppressed
    sel = 0; wreg = 0; rw = 1; vin = 1;
    cycle("t4");
    check("t4_we_const", 32'(we_o), 0);
    check("t4_valid_const", 32'(v_o), 1);

    // 5: stall holds, flush wins over stall
    wreg = 7;
    cycle("t5_pre");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle("t5_stall");
      check("t5_stall_data", wd_o, src0 === 32'hx ? 0 : m_data);
    end
    flush = 1;
    cycle("t5_flush");
    check("t5_flush_valid", 32'(v_o), 0);
    check("t5_flush_we", 32'(we_o), 0);
    stall = 0; flush = 0;

    // 6: out-of-range selector, sticky error
    src0 = 32'hCAFEF00D; src2 = 32'h12345678; sel = 3; vin = 1; rw = 1; wreg = 9;
    cycle("t6_bad");
    check("t6_data_const", wd_o, 32'hCAFEF00D);
    check("t6_serr_const", 32'(se_o), 1);
    sel = 2;
    cycle("t6_good");
    check("t6_sticky", 32'(se_o), 1);

    // counter wrap on the 4-bit build
    rst = 1;
    cycle("t6_rst");
    check("t6_serr_rst", 32'(se_o), 0);
    rst = 0; vin = 1; sel = 0;
    for (int i = 0; i < 15; i++) cycle("t6_cnt");
    check("t6_cnt_full", 32'(cnt_o), 15);
    cycle("t6_wrap");
    check("t6_cnt_wrap", 32'(cnt_o), 0);

    // random traffic, including reset during stall/flush
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
